// File: rtl/robertson_pkg.sv
// -----------------------------------------------------------------------------
// robertson_pkg
// Shared types and helpers for the Robertson signed multiplier.
//   DW_DEFAULT    default operand width (product is 2*DW_DEFAULT)
//   CNTW_DEFAULT  default width of the iteration-counter value port
//   state_t       controller states IDLE -> ITER -> DONE
//   step_t        per-iteration arithmetic operation on the partial product
//   step_sel()    picks the operation from the current multiplier LSB and
//                 whether this is the final (sign-bit) iteration
// -----------------------------------------------------------------------------
package robertson_pkg;

  localparam int DW_DEFAULT   = 8;
  localparam int CNTW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    STEP_NOP,
    STEP_ADD,
    STEP_SUB
  } step_t;

  // The multiplier's sign bit carries weight -2^(DW-1), so its partial
  // product is subtracted instead of added on the last iteration.
  function automatic step_t step_sel(input logic q_lsb, input logic last);
    if (!q_lsb) return STEP_NOP;
    return last ? STEP_SUB : STEP_ADD;
  endfunction

endpackage

// File: rtl/robertson_datapath.sv
// -----------------------------------------------------------------------------
// robertson_datapath
// A/Q/M register file plus the (DW+1)-bit add/sub and arithmetic right shift
// of one Robertson iteration.
// Ports:
//   clk     in   1     clock, all registers on posedge
//   reset   in   1     synchronous, active-low
//   load    in   1     A<=0, Q<=mplier, M<=mcand
//   step    in   1     perform one add/sub-and-shift iteration
//   op      in   step_t  operation for this iteration (NOP/ADD/SUB)
//   mcand   in   DW    multiplicand to load into M
//   mplier  in   DW    multiplier to load into Q
//   a       out  DW    upper half of the partial product
//   q       out  DW    lower half of the partial product / remaining multiplier
// -----------------------------------------------------------------------------
module robertson_datapath
  import robertson_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  step_t         op,
  input  logic [DW-1:0] mcand,
  input  logic [DW-1:0] mplier,
  output logic [DW-1:0] a,
  output logic [DW-1:0] q
);

  logic [DW-1:0] m;
  logic [DW:0]   a_ext;
  logic [DW:0]   m_ext;
  logic [DW:0]   sum;

  // One extra bit keeps the true sign of A +/- M, so the arithmetic shift
  // never loses it (needed for -2^(DW-1) * -2^(DW-1)).
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path through the case statement leaves it unassigned (which would infer a latch).
    a_ext = {a[DW-1], a};
    m_ext = {m[DW-1], m};
    sum   = a_ext;
    case (op)
      STEP_ADD: sum = a_ext + m_ext;
      STEP_SUB: sum = a_ext - m_ext;
      default:  sum = a_ext;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    // NOTE: A/Q/M are ordinary flops, not a memory, so they are reset; the
    // product output then reads zero after reset.
    if (!reset) begin
      a <= '0;
      q <= '0;
      m <= '0;
    end else if (load) begin
      a <= '0;
      q <= mplier;
      m <= mcand;
    end else if (step) begin
      // Arithmetic shift right of {sum, q}: sum's MSB becomes A's sign.
      a <= sum[DW:1];
      q <= {sum[0], q[DW-1:1]};
    end
  end

endmodule

// File: rtl/robertson_mult_ctrl.sv
// -----------------------------------------------------------------------------
// robertson_mult_ctrl
// Sequential signed (two's complement) multiplier, Robertson's algorithm.
// FSM, valid/ready handshakes and control of an external down counter that
// supplies the iteration count; the arithmetic lives in robertson_datapath.
// Ports:
//   clk        in   1       clock, all logic on posedge
//   reset      in   1       synchronous, active-low (0 = reset)
//   in_valid   in   1       operand pair valid
//   in_ready   out  1       operands accepted (high only in IDLE)
//   mcand      in   DW      signed multiplicand
//   mplier     in   DW      signed multiplier
//   cnt_reset  out  1       preload external down counter to DW-1
//   cnt_ena    out  1       decrement external down counter
//   cnt_val    in   CNTW    current counter value (0 marks the sign-bit step)
//   out_valid  out  1       product valid, held until accepted
//   out_ready  in   1       sink accepts product
//   product    out  2*DW    signed product, stable while out_valid
// Configuration:
//   ROBERTSON_ZERO_SKIP_EN  when defined, a zero operand skips the iterations
//                           and the product (0) is valid one cycle after accept.
// -----------------------------------------------------------------------------
module robertson_mult_ctrl
  import robertson_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int CNTW = CNTW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   mcand,
  input  logic [DW-1:0]   mplier,
  output logic            cnt_reset,
  output logic            cnt_ena,
  input  logic [CNTW-1:0] cnt_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] product
);

  state_t        state;
  logic          accept;
  logic          last;
  logic          skip;
  logic [DW-1:0] mplier_load;
  logic [DW-1:0] a;
  logic [DW-1:0] q;
  step_t         op;

  assign accept = (state == IDLE) && in_valid && in_ready;
  assign last   = (cnt_val == '0);
  assign op     = step_sel(q[0], last);

`ifdef ROBERTSON_ZERO_SKIP_EN
  assign skip = (mcand == '0) || (mplier == '0);
`else
  assign skip = 1'b0;
`endif

  // A skipped operation loads Q with zero so {A,Q} already holds the product.
  assign mplier_load = skip ? '0 : mplier;

  // Outputs are registered alongside the state: each transition sets the
  // output values of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      cnt_reset <= 1'b1;
      cnt_ena   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready  <= 1'b0;
            cnt_reset <= 1'b0;
            if (skip) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state   <= ITER;
              cnt_ena <= 1'b1;
            end
          end
        end
        ITER: begin
          // Counter value 0 is the sign-bit iteration; a larger value than
          // DW-1 simply keeps iterating.
          if (last) begin
            state     <= DONE;
            cnt_ena   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // in_ready stays low through the handshake cycle; the next
          // operand pair can be taken one cycle later.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            cnt_reset <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          cnt_reset <= 1'b1;
          cnt_ena   <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  robertson_datapath #(
    .DW (DW)
  ) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   (state == ITER),
    .op     (op),
    .mcand  (mcand),
    .mplier (mplier_load),
    .a      (a),
    .q      (q)
  );

  assign product = {a, q};

endmodule

// File: tb/tb_robertson_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_robertson_mult_ctrl
// Self-checking bench for robertson_mult_ctrl (DW=8). A small 7-bit down
// counter stands in for the lab counter. Expected products come from plain
// signed multiplication; expected latency from the accept-to-valid rule.
// Honours ROBERTSON_ZERO_SKIP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_robertson_mult_ctrl;

  localparam int DW       = 8;
  localparam int CNTW     = 8;
  localparam int N_RANDOM = 3000;
  localparam int BUDGET   = 64;

  logic            clk       = 1'b0;
  logic            reset     = 1'b0;
  logic            in_valid  = 1'b0;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   mcand     = '0;
  logic [DW-1:0]   mplier    = '0;
  logic            in_ready;
  logic            cnt_reset;
  logic            cnt_ena;
  logic            out_valid;
  logic [CNTW-1:0] cnt_val;
  logic [2*DW-1:0] product;

  logic [6:0]      cnt = 7'(DW - 1);

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Lab down counter, WIDTH=7: preload to DW-1, decrement when enabled.
  always @(posedge clk) begin
    if (cnt_reset)    cnt <= 7'(DW - 1);
    else if (cnt_ena) cnt <= cnt - 7'd1;
  end
  assign cnt_val = CNTW'(cnt);

  robertson_mult_ctrl #(
    .DW   (DW),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .mplier    (mplier),
    .cnt_reset (cnt_reset),
    .cnt_ena   (cnt_ena),
    .cnt_val   (cnt_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  // ---------------- reference model ----------------
  function automatic logic [2*DW-1:0] ref_product(input logic [DW-1:0] x, input logic [DW-1:0] y);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return (2*DW)'(sx * sy);
  endfunction

  // Cycles from the accept cycle (cycle 0) to the first cycle with out_valid.
  function automatic int ref_latency(input logic [DW-1:0] x, input logic [DW-1:0] y);
`ifdef ROBERTSON_ZERO_SKIP_EN
    if (x == '0 || y == '0) return 1;
`endif
    return DW + 1;
  endfunction

  function automatic logic [DW-1:0] pick_operand();
    logic [DW-1:0] corner [5];
    corner = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01};
    if ($urandom_range(7) == 0) return corner[$urandom_range(4)];
    return DW'($urandom);
  endfunction

  // ---------------- driver ----------------
  // Presents one operand pair, returns the product seen in the first
  // out_valid cycle and the latency. Returns at the negedge of that cycle.
  task automatic do_op(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic rdy,
                       output logic [2*DW-1:0] prod, output int lat);
    int guard;
    prod = 'x;
    lat  = 0;
    @(negedge clk);
    guard = 0;
    while (in_ready !== 1'b1 && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) return;
    mcand     = x;
    mplier    = y;
    in_valid  = 1'b1;
    out_ready = rdy;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (out_valid !== 1'b1 && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    if (out_valid === 1'b1) prod = product;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if (cnt_reset !== 1'b1) begin n_bad++; $display("FAIL reset cnt_reset: got %b want 1", cnt_reset); end
    n_cmp++; if (cnt_ena !== 1'b0)   begin n_bad++; $display("FAIL reset cnt_ena: got %b want 0", cnt_ena); end
    n_cmp++; if (product !== '0)     begin n_bad++; $display("FAIL reset product: got %h want 0", product); end
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [DW-1:0]   xs [4];
    logic [DW-1:0]   ys [4];
    logic [2*DW-1:0] ps [4];
    logic [2*DW-1:0] prod;
    int              lat;
    xs = '{8'd3,  8'h80,     8'hF9,     8'h7F};
    ys = '{8'd5,  8'h80,     8'd6,      8'hFF};
    ps = '{16'd15, 16'd16384, 16'hFFD6, 16'hFF81};
    for (int i = 0; i < 4; i++) begin
      do_op(xs[i], ys[i], 1'b1, prod, lat);
      n_cmp++;
      if (prod !== ps[i]) begin
        n_bad++;
        $display("FAIL directed product %0d: got %0d want %0d", i, $signed(prod), $signed(ps[i]));
      end
      n_cmp++;
      if (lat !== DW + 1) begin
        n_bad++;
        $display("FAIL directed latency %0d: got %0d want %0d", i, lat, DW + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2*DW-1:0] prod;
    logic [2*DW-1:0] want;
    int              lat;
    want = ref_product(8'd13, 8'hF6);
    do_op(8'd13, 8'hF6, 1'b0, prod, lat);
    n_cmp++;
    if (prod !== want) begin n_bad++; $display("FAIL backpressure product: got %0d want %0d", $signed(prod), $signed(want)); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || product !== want || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure hold %0d: out_valid=%b product=%0d in_ready=%b want 1/%0d/0",
                 i, out_valid, $signed(product), in_ready, $signed(want));
      end
    end
    out_ready = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL handshake in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_ignore_busy();
    int   guard;
    int   lat;
    logic busy_ok;
    @(negedge clk);
    guard = 0;
    while (in_ready !== 1'b1 && guard < BUDGET) begin @(negedge clk); guard++; end
    mcand = 8'hF9; mplier = 8'd6; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    mcand = 8'd100; mplier = 8'd100;
    busy_ok = 1'b1;
    lat     = 1;
    while (out_valid !== 1'b1 && lat < BUDGET) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (busy_ok !== 1'b1) begin n_bad++; $display("FAIL busy in_ready: got high during ITER, want 0"); end
    n_cmp++;
    if (product !== ref_product(8'hF9, 8'd6)) begin
      n_bad++; $display("FAIL busy product: got %0d want %0d", $signed(product), $signed(ref_product(8'hF9, 8'd6)));
    end
    n_cmp++;
    if (lat !== ref_latency(8'hF9, 8'd6)) begin
      n_bad++; $display("FAIL busy latency: got %0d want %0d", lat, ref_latency(8'hF9, 8'd6));
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [DW-1:0]   xs [2];
    logic [DW-1:0]   ys [2];
    logic [2*DW-1:0] prod;
    int              lat;
    xs = '{8'd0,  8'd55};
    ys = '{8'd55, 8'd0};
    for (int i = 0; i < 2; i++) begin
      do_op(xs[i], ys[i], 1'b1, prod, lat);
      n_cmp++;
      if (prod !== '0) begin n_bad++; $display("FAIL zero product %0d: got %0d want 0", i, $signed(prod)); end
      n_cmp++;
      if (lat !== ref_latency(xs[i], ys[i])) begin
        n_bad++; $display("FAIL zero latency %0d: got %0d want %0d", i, lat, ref_latency(xs[i], ys[i]));
      end
    end
  endtask

  task automatic test_mid_reset();
    int   guard;
    logic seen;
    @(negedge clk);
    guard = 0;
    while (in_ready !== 1'b1 && guard < BUDGET) begin @(negedge clk); guard++; end
    mcand = 8'd3; mplier = 8'd5; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL abort in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort out_valid: got %b want 0", out_valid); end
    n_cmp++; if (cnt_reset !== 1'b1) begin n_bad++; $display("FAIL abort cnt_reset: got %b want 1", cnt_reset); end
    n_cmp++; if (cnt_ena !== 1'b0)   begin n_bad++; $display("FAIL abort cnt_ena: got %b want 0", cnt_ena); end
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 2 * DW; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL abort product issued: out_valid rose after reset, want none"); end
  endtask

  task automatic test_random();
    logic [DW-1:0]   x;
    logic [DW-1:0]   y;
    logic [2*DW-1:0] prod;
    int              lat;
    for (int i = 0; i < N_RANDOM; i++) begin
      x = pick_operand();
      y = pick_operand();
      do_op(x, y, 1'b1, prod, lat);
      n_cmp++;
      if (prod !== ref_product(x, y)) begin
        n_bad++;
        $display("FAIL random product %0d (%0d * %0d): got %0d want %0d",
                 i, $signed(x), $signed(y), $signed(prod), $signed(ref_product(x, y)));
      end
      n_cmp++;
      if (lat !== ref_latency(x, y)) begin
        n_bad++;
        $display("FAIL random latency %0d: got %0d want %0d", i, lat, ref_latency(x, y));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_busy();
    test_zero();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
